// File: rtl/pbvi_iter_sched.sv
`default_nettype none
// ============================================================================
// Module      : pbvi_iter_sched
// Description : Iteration scheduler for the PBVI value-backup loop. Runs the
//               gamma-generation, projection and argmax stages in order once
//               per iteration, tracks the per-point action vector to detect
//               convergence, enforces the iteration budget and guards every
//               stage with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pbvi_iter_sched #(
  parameter int NPOINT       = 16,
  parameter int ITER_W       = 8,
  parameter int STABLE_ITERS = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ITER_W-1:0]   max_iter,
  output logic                step1_start,
  input  logic                step1_done,
  output logic                step2_start,
  input  logic                step2_done,
  output logic                step3_en,
  input  logic                step3_done,
  input  logic [2*NPOINT-1:0] point_action_in,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic                timeout_err
);

  // The watchdog never counts past TIMEOUT-1, so log2(TIMEOUT) bits suffice.
  localparam int                c_WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LIMIT   = c_WD_W'(TIMEOUT - 1);
  localparam logic [ITER_W-1:0] c_STABLE_LIM = ITER_W'(STABLE_ITERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S1     = 3'd1,
    ST_S2     = 3'd2,
    ST_S3     = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_WD_W-1:0]   r_wdog;
  logic [ITER_W-1:0]   r_max_iter;
  logic [ITER_W-1:0]   r_stable_cnt;
  logic                r_prev_valid;
  logic [2*NPOINT-1:0] r_prev_action;
  logic [2*NPOINT-1:0] r_cur_action;
  logic                w_match;
  logic [ITER_W-1:0]   w_stable_nxt;
  logic [ITER_W-1:0]   w_iter_nxt;
  logic                w_conv;
  logic                w_wd_expired;
  logic                w_in_stage;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort beats every done input and the watchdog, and a
  // done arriving on the watchdog limit cycle still wins over the error.
  always_comb begin
    w_state_nxt  = r_state;
    w_match      = r_prev_valid && (r_cur_action == r_prev_action);
    w_stable_nxt = w_match ? (r_stable_cnt + ITER_W'(1)) : '0;
    w_iter_nxt   = iter_cnt + ITER_W'(1);
    w_conv       = r_prev_valid && (w_stable_nxt >= c_STABLE_LIM);
    w_wd_expired = (r_wdog == c_WD_LIMIT);
    w_in_stage   = (r_state == ST_S1) || (r_state == ST_S2) || (r_state == ST_S3);
    if ((r_state != ST_IDLE) && abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) w_state_nxt = ST_S1;
        ST_S1:     if (step1_done) w_state_nxt = ST_S2;
                   else if (w_wd_expired) w_state_nxt = ST_ERR;
        ST_S2:     if (step2_done) w_state_nxt = ST_S3;
                   else if (w_wd_expired) w_state_nxt = ST_ERR;
        ST_S3:     if (step3_done) w_state_nxt = ST_CHECK;
                   else if (w_wd_expired) w_state_nxt = ST_ERR;
        ST_CHECK:  if (w_conv || (w_iter_nxt == r_max_iter)) w_state_nxt = ST_FINISH;
                   else w_state_nxt = ST_S1;
        ST_FINISH: w_state_nxt = ST_IDLE;
        ST_ERR:    w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered outputs, watchdog and iteration bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step1_start   <= 1'b0;
      step2_start   <= 1'b0;
      step3_en      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      iter_cnt      <= '0;
      timeout_err   <= 1'b0;
      r_wdog        <= '0;
      r_max_iter    <= '0;
      r_stable_cnt  <= '0;
      r_prev_valid  <= 1'b0;
      r_prev_action <= '0;
      r_cur_action  <= '0;
    end else begin
      // Strobes fire only on the edge that enters their stage.
      step1_start <= (w_state_nxt == ST_S1) && (r_state != ST_S1);
      step2_start <= (w_state_nxt == ST_S2) && (r_state != ST_S2);
      step3_en    <= (w_state_nxt == ST_S3) && (r_state != ST_S3);
      busy        <= (w_state_nxt != ST_IDLE);
      done        <= (w_state_nxt == ST_FINISH);

      if (w_state_nxt != r_state) r_wdog <= '0;
      else if (w_in_stage)        r_wdog <= r_wdog + c_WD_W'(1);

      if (w_state_nxt == ST_ERR) timeout_err <= 1'b1;

      if ((r_state == ST_IDLE) && start) begin
        iter_cnt     <= '0;
        r_stable_cnt <= '0;
        r_prev_valid <= 1'b0;
        converged    <= 1'b0;
        timeout_err  <= 1'b0;
        r_max_iter   <= (max_iter == '0) ? ITER_W'(1) : max_iter;
      end

      if ((r_state == ST_S3) && step3_done && !abort) r_cur_action <= point_action_in;

      if ((r_state == ST_CHECK) && !abort) begin
        iter_cnt      <= w_iter_nxt;
        r_stable_cnt  <= w_stable_nxt;
        r_prev_action <= r_cur_action;
        r_prev_valid  <= 1'b1;
        if (w_conv) converged <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pbvi_iter_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pbvi_iter_sched
// Description : Directed self-checking bench for pbvi_iter_sched. A stage
//               responder answers each strobe after a programmable delay (or
//               in the same cycle) and a monitor records strobe order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pbvi_iter_sched;
  localparam int NPOINT = 16;
  localparam int ITER_W = 8;
  localparam int AW     = 2 * NPOINT;

  logic              clk = 1'b0;
  logic              rst_n, start, abort;
  logic [ITER_W-1:0] max_iter;
  logic              step1_start, step2_start, step3_en;
  logic              step1_done, step2_done, step3_done;
  logic [AW-1:0]     point_action_in;
  logic              busy, done, converged, timeout_err;
  logic [ITER_W-1:0] iter_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit            tie_mode = 1'b0;
  bit            s2_mute  = 1'b0;
  int            dly1 = 3, dly2 = 3, dly3 = 3;
  int            c1 = 0, c2 = 0, c3 = 0;
  logic          d1_r = 1'b0, d2_r = 1'b0, d3_r = 1'b0;
  logic [AW-1:0] act_tab [16];
  int            s3_count = 0;

  int n1 = 0, n2 = 0, n3 = 0, n_done = 0, seq_err = 0, exp_stage = 1;

  always #5 clk = ~clk;

  pbvi_iter_sched #(
    .NPOINT(NPOINT), .ITER_W(ITER_W), .STABLE_ITERS(3), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_iter(max_iter),
    .step1_start(step1_start), .step1_done(step1_done),
    .step2_start(step2_start), .step2_done(step2_done),
    .step3_en(step3_en), .step3_done(step3_done),
    .point_action_in(point_action_in),
    .busy(busy), .done(done), .converged(converged),
    .iter_cnt(iter_cnt), .timeout_err(timeout_err)
  );

  assign step1_done = tie_mode ? step1_start : d1_r;
  assign step2_done = tie_mode ? step2_start : (d2_r & ~s2_mute);
  assign step3_done = tie_mode ? step3_en    : d3_r;

  // Stage responder: done pulses dlyN cycles after each strobe.
  initial begin
    point_action_in = '0;
    forever begin
      @(negedge clk);
      d1_r = 1'b0; d2_r = 1'b0; d3_r = 1'b0;
      if (step1_start) c1 = dly1;
      else if (c1 > 0) begin c1--; if (c1 == 0) d1_r = 1'b1; end
      if (step2_start) c2 = dly2;
      else if (c2 > 0) begin c2--; if (c2 == 0) d2_r = 1'b1; end
      if (step3_en) begin
        c3 = dly3;
        point_action_in = act_tab[s3_count[3:0]];
        s3_count++;
      end else if (c3 > 0) begin c3--; if (c3 == 0) d3_r = 1'b1; end
    end
  end

  // Monitor: counts strobes and done pulses, flags out-of-order strobes.
  initial begin
    forever begin
      @(negedge clk);
      if (step1_start) begin n1++; if (exp_stage != 1) seq_err++; exp_stage = 2; end
      if (step2_start) begin n2++; if (exp_stage != 2) seq_err++; exp_stage = 3; end
      if (step3_en)    begin n3++; if (exp_stage != 3) seq_err++; exp_stage = 1; end
      if (done) n_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  task automatic clear_counts;
    n1 = 0; n2 = 0; n3 = 0; n_done = 0; seq_err = 0; exp_stage = 1; s3_count = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses start for one cycle; returns at the negedge of the first S1 cycle.
  task automatic start_run(input logic [ITER_W-1:0] mi);
    @(negedge clk);
    max_iter = mi;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Waits for done; cyc is the cycle index counted from the start cycle (0).
  task automatic run_to_done(output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({step1_start, step2_start, step3_en, busy, done, converged, timeout_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {step1_start, step2_start, step3_en, busy, done, converged, timeout_err});
    end
    n_checks++;
    if (iter_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_iter_cnt: got %0d expected 0", iter_cnt); end
  endtask

  task automatic test_budget;
    int cyc; bit ok;
    tie_mode = 1'b0; dly1 = 3; dly2 = 3; dly3 = 3; s2_mute = 1'b0;
    for (int i = 0; i < 16; i++) act_tab[i] = 32'hA500_0000 | 32'(i);
    clear_counts();
    start_run(8'd4);
    run_to_done(cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL budget_done_seen: got no done expected done"); end
    n_checks++;
    if (cyc !== 53) begin n_fail++; $display("FAIL budget_done_cycle: got %0d expected 53", cyc); end
    n_checks++;
    if (converged !== 1'b0) begin n_fail++; $display("FAIL budget_converged: got %b expected 0", converged); end
    n_checks++;
    if (iter_cnt !== 8'd4) begin n_fail++; $display("FAIL budget_iter_cnt: got %0d expected 4", iter_cnt); end
    n_checks++;
    if ({n1, n2, n3} !== {32'd4, 32'd4, 32'd4}) begin
      n_fail++; $display("FAIL budget_strobes: got %0d/%0d/%0d expected 4/4/4", n1, n2, n3);
    end
    n_checks++;
    if (seq_err !== 0) begin n_fail++; $display("FAIL budget_order: got %0d errors expected 0", seq_err); end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL budget_after: got done,busy=%b expected 00", {done, busy}); end
    n_checks++;
    if (iter_cnt !== 8'd4) begin n_fail++; $display("FAIL budget_iter_hold: got %0d expected 4", iter_cnt); end
  endtask

  task automatic test_converge;
    int cyc; bit ok;
    act_tab[0] = 32'h1234_5678;
    for (int i = 1; i < 16; i++) act_tab[i] = 32'h9ABC_DEF0;
    clear_counts();
    start_run(8'd10);
    run_to_done(cyc, ok);
    n_checks++;
    if (!ok || cyc !== 53) begin n_fail++; $display("FAIL conv_done_cycle: got %0d (ok=%b) expected 53", cyc, ok); end
    n_checks++;
    if (converged !== 1'b1) begin n_fail++; $display("FAIL conv_flag: got %b expected 1", converged); end
    n_checks++;
    if (iter_cnt !== 8'd4) begin n_fail++; $display("FAIL conv_iter_cnt: got %0d expected 4", iter_cnt); end
    settle(5);
    n_checks++;
    if (n1 !== 4) begin n_fail++; $display("FAIL conv_no_extra_s1: got %0d expected 4", n1); end
    n_checks++;
    if ({converged, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL conv_hold: got conv,busy,done=%b expected 100", {converged, busy, done});
    end
  endtask

  task automatic test_same_cycle;
    int cyc; bit ok;
    tie_mode = 1'b1;
    for (int i = 0; i < 16; i++) act_tab[i] = 32'h0F00_0000 + 32'(i * 3);
    clear_counts();
    start_run(8'd0);
    n_checks++;
    if ({converged, step1_start, busy} !== 3'b011) begin
      n_fail++; $display("FAIL same_first_cycle: got conv,s1,busy=%b expected 011", {converged, step1_start, busy});
    end
    run_to_done(cyc, ok);
    n_checks++;
    if (!ok || cyc !== 5) begin n_fail++; $display("FAIL same_maxiter0_cycle: got %0d (ok=%b) expected 5", cyc, ok); end
    n_checks++;
    if (iter_cnt !== 8'd1) begin n_fail++; $display("FAIL same_maxiter0_iter: got %0d expected 1", iter_cnt); end
    settle(2);
    clear_counts();
    start_run(8'd3);
    run_to_done(cyc, ok);
    n_checks++;
    if (!ok || cyc !== 13) begin n_fail++; $display("FAIL same_3iter_cycle: got %0d (ok=%b) expected 13", cyc, ok); end
    n_checks++;
    if ({iter_cnt, converged} !== {8'd3, 1'b0}) begin
      n_fail++; $display("FAIL same_3iter_result: got iter=%0d conv=%b expected iter=3 conv=0", iter_cnt, converged);
    end
    n_checks++;
    if (n1 !== 3 || seq_err !== 0) begin n_fail++; $display("FAIL same_3iter_strobes: got n1=%0d seq_err=%0d expected 3/0", n1, seq_err); end
    tie_mode = 1'b0;
    settle(2);
  endtask

  task automatic test_wd_boundary;
    int cyc; bit ok;
    dly1 = 63;
    clear_counts();
    start_run(8'd1);
    run_to_done(cyc, ok);
    n_checks++;
    if (!ok || cyc !== 74) begin n_fail++; $display("FAIL wdb_done_cycle: got %0d (ok=%b) expected 74", cyc, ok); end
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wdb_no_error: got %b expected 0", timeout_err); end
    dly1 = 3;
    settle(2);
  endtask

  task automatic test_watchdog;
    int cyc, t2, te; bit ok;
    s2_mute = 1'b1;
    clear_counts();
    start_run(8'd4);
    cyc = 1; t2 = -1; te = -1;
    for (int i = 0; i < 300; i++) begin
      if (step2_start && t2 < 0) t2 = cyc;
      if (timeout_err) begin te = cyc; break; end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (te - t2 !== 64 || t2 !== 5) begin n_fail++; $display("FAIL wd_latency: got s2@%0d err@%0d expected s2@5 err@69", t2, te); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL wd_busy_in_err: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++;
    if ({busy, timeout_err} !== 2'b01) begin n_fail++; $display("FAIL wd_after: got busy,err=%b expected 01", {busy, timeout_err}); end
    settle(4);
    n_checks++;
    if (n_done !== 0 || iter_cnt !== 8'd0 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL wd_sticky: got done_cnt=%0d iter=%0d err=%b expected 0/0/1", n_done, iter_cnt, timeout_err);
    end
    s2_mute = 1'b0;
    tie_mode = 1'b1;
    clear_counts();
    start_run(8'd1);
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_cleared_by_start: got %b expected 0", timeout_err); end
    run_to_done(cyc, ok);
    n_checks++;
    if (!ok || cyc !== 5) begin n_fail++; $display("FAIL wd_rerun: got %0d (ok=%b) expected 5", cyc, ok); end
    tie_mode = 1'b0;
    settle(2);
  endtask

  task automatic test_abort;
    int seen;
    for (int i = 0; i < 16; i++) act_tab[i] = 32'h5500_0000 | 32'(i);
    clear_counts();
    start_run(8'd4);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (step3_en) begin seen++; if (seen == 2) break; end
    end
    n_checks++;
    if (seen !== 2) begin n_fail++; $display("FAIL abort_find_s3: got %0d S3 strobes expected 2", seen); end
    settle(3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got busy,done=%b expected 00", {busy, done}); end
    n_checks++;
    if (iter_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_iter_cnt: got %0d expected 1", iter_cnt); end
    settle(6);
    n_checks++;
    if (n_done !== 0 || n1 !== 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: got done_cnt=%0d n1=%0d busy=%b expected 0/2/0", n_done, n1, busy);
    end
    max_iter = 8'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, step1_start} !== 2'b11) begin n_fail++; $display("FAIL abort_start_wins: got busy,s1=%b expected 11", {busy, step1_start}); end
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, step1_start, step2_start, iter_cnt} !== {3'b000, 8'd0}) begin
      n_fail++; $display("FAIL abort_in_s1: got busy=%b s1=%b s2=%b iter=%0d expected 0/0/0/0", busy, step1_start, step2_start, iter_cnt);
    end
    settle(8);
  endtask

  task automatic test_reset_midrun;
    int cyc; bit ok; bit found;
    for (int i = 0; i < 16; i++) act_tab[i] = 32'h7700_0000 | 32'(i);
    clear_counts();
    start_run(8'd4);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (step2_start) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_find_s2: got no step2_start expected one"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({step1_start, step2_start, step3_en, busy, done, converged, timeout_err, iter_cnt} !== 15'd0) begin
      n_fail++; $display("FAIL rst_midrun_outputs: got busy=%b iter=%0d expected all zero", busy, iter_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle(8);
    for (int i = 0; i < 16; i++) act_tab[i] = 32'hC3C3_0F0F;
    clear_counts();
    start_run(8'd10);
    run_to_done(cyc, ok);
    n_checks++;
    if (!ok || cyc !== 40) begin n_fail++; $display("FAIL rst_fresh_cycle: got %0d (ok=%b) expected 40", cyc, ok); end
    n_checks++;
    if ({converged, iter_cnt} !== {1'b1, 8'd3}) begin
      n_fail++; $display("FAIL rst_fresh_result: got conv=%b iter=%0d expected conv=1 iter=3", converged, iter_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; max_iter = '0;
    for (int i = 0; i < 16; i++) act_tab[i] = '0;
    settle(3);
    test_reset();
    rst_n = 1'b1;
    settle(2);
    test_budget();
    test_converge();
    test_same_cycle();
    test_wd_boundary();
    test_watchdog();
    test_abort();
    test_reset_midrun();
    settle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
